// File: rtl/frame_symbol_sender_pkg.sv
// Shared frame definitions for the symbol sender and the decoding end of the link.
package frame_symbol_sender_pkg;

    localparam int unsigned SYM_W     = 3;
    localparam int unsigned NUM_LINES = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    localparam logic [SYM_W-1:0] SYM_FS  = 3'd0;
    localparam logic [SYM_W-1:0] SYM_CH  = 3'd1;
    localparam logic [SYM_W-1:0] SYM_X0  = 3'd2;
    localparam logic [SYM_W-1:0] SYM_DIR = 3'd3;
    localparam logic [SYM_W-1:0] SYM_FE  = 3'd4;

    // One-hot line codes, bit order {zero, one, fe, x0, fs}
    localparam logic [NUM_LINES-1:0] LINE_FS   = 5'b00001;
    localparam logic [NUM_LINES-1:0] LINE_X0   = 5'b00010;
    localparam logic [NUM_LINES-1:0] LINE_FE   = 5'b00100;
    localparam logic [NUM_LINES-1:0] LINE_ONE  = 5'b01000;
    localparam logic [NUM_LINES-1:0] LINE_ZERO = 5'b10000;

    function automatic logic [NUM_LINES-1:0] sym_line(input logic [SYM_W-1:0] idx,
                                                       input logic ch, input logic up);
        logic [NUM_LINES-1:0] l;
        l = '0;
        case (idx)
            SYM_FS:  l = LINE_FS;
            SYM_CH:  l = ch ? LINE_ONE : LINE_ZERO;
            SYM_X0:  l = LINE_X0;
            SYM_DIR: l = up ? LINE_ONE : LINE_ZERO;
            SYM_FE:  l = LINE_FE;
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/frame_symbol_sender_ack_sync.sv
// Two-flop synchroniser for one asynchronous acknowledge line, resets to 0.
module ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/frame_symbol_sender.sv
// Sends one motor command as an FS/CH/X0/DIR/FE symbol frame with four-phase acks.
// Optional ack timeout with err pulse when FRAME_TIMEOUT_EN is defined.
module frame_symbol_sender
    import frame_symbol_sender_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_channel,
    input  logic cmd_up,
    output logic cmd_ready,
    output logic fs,
    output logic x0,
    output logic fe,
    output logic one,
    output logic zero,
    input  logic fs_ack,
    input  logic x0_ack,
    input  logic fe_ack,
    input  logic one_ack,
    input  logic zero_ack,
    output logic done,
    output logic err
);

    logic [NUM_LINES-1:0] ack_raw;
    logic [NUM_LINES-1:0] ack_s;

    assign ack_raw = {zero_ack, one_ack, fe_ack, x0_ack, fs_ack};

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_sync
        ack_sync u_ack_sync (
            .clk (clk),
            .rst (rst),
            .d_i (ack_raw[g]),
            .q_o (ack_s[g])
        );
    end

    state_e               state_q;
    logic [SYM_W-1:0]     idx_q;
    logic                 ch_q;
    logic                 up_q;
    logic [NUM_LINES-1:0] lines_q;
    logic                 ready_q;
    logic                 done_q;

    logic [NUM_LINES-1:0] sel_c;
    logic [SYM_W-1:0]     idx_next_c;
    logic                 ack_match_c;
    logic                 timeout_c;

    // Only the ack belonging to the current symbol's line is considered
    assign sel_c       = sym_line(idx_q, ch_q, up_q);
    assign ack_match_c = |(ack_s & sel_c);
    assign idx_next_c  = SYM_W'(idx_q + 1'b1);

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             waiting_c;

    assign waiting_c = ((state_q == WAIT_HI) && !ack_match_c) ||
                       ((state_q == WAIT_LO) &&  ack_match_c);
    assign timeout_c = waiting_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts whenever a wait is satisfied or abandoned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_c;
            cnt_q <= waiting_c ? CNT_W'(cnt_q + 1'b1) : '0;
        end
    end

    assign err = err_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout_c  = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= SYM_FS;
            ch_q    <= 1'b0;
            up_q    <= 1'b0;
            lines_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        idx_q   <= SYM_FS;
                        ch_q    <= cmd_channel;
                        up_q    <= cmd_up;
                        lines_q <= sym_line(SYM_FS, cmd_channel, cmd_up);
                        ready_q <= 1'b0;
                        state_q <= RAISE;
                    end
                end
                RAISE: begin
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (ack_match_c) begin
                        lines_q <= '0;
                        state_q <= WAIT_LO;
                    end else if (timeout_c) begin
                        lines_q <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                WAIT_LO: begin
                    if (!ack_match_c) begin
                        if (idx_q == SYM_FE) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_next_c;
                            lines_q <= sym_line(idx_next_c, ch_q, up_q);
                            state_q <= RAISE;
                        end
                    end else if (timeout_c) begin
                        lines_q <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    lines_q <= '0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {zero, one, fe, x0, fs} = lines_q;
    assign cmd_ready               = ready_q;
    assign done                    = done_q;

endmodule

// File: tb/tb_frame_symbol_sender.sv
// Scoreboard bench: expected line/done sequence queued per command, checked on each line rise.
module tb_frame_symbol_sender;
    import frame_symbol_sender_pkg::*;

    localparam int unsigned TO_CYC = 16;
    localparam logic [5:0]  TOK_DONE = 6'b100000;

    logic clk = 1'b0;
    logic rst;
    logic cmd_valid, cmd_channel, cmd_up, cmd_ready;
    logic fs, x0, fe, one, zero;
    logic fs_ack, x0_ack, fe_ack, one_ack, zero_ack;
    logic done, err;

    always #5 clk = ~clk;

    frame_symbol_sender #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_channel (cmd_channel),
        .cmd_up      (cmd_up),
        .cmd_ready   (cmd_ready),
        .fs          (fs),
        .x0          (x0),
        .fe          (fe),
        .one         (one),
        .zero        (zero),
        .fs_ack      (fs_ack),
        .x0_ack      (x0_ack),
        .fe_ack      (fe_ack),
        .one_ack     (one_ack),
        .zero_ack    (zero_ack),
        .done        (done),
        .err         (err)
    );

    logic [4:0] lines;
    logic [4:0] auto_ack, force_ack, auto_en;
    int         hi_cnt [5];
    int         lo_cnt [5];

    assign lines = {zero, one, fe, x0, fs};
    assign {zero_ack, one_ack, fe_ack, x0_ack, fs_ack} = auto_ack | force_ack;

    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [5:0] exp_q [$];
    logic [4:0] prev;
    logic [4:0] rise;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Receiver model: ack 3 cycles after rise, release 3 cycles after fall
    always @(negedge clk) begin
        if (rst) begin
            auto_ack = '0;
            for (int i = 0; i < 5; i++) begin
                hi_cnt[i] = 0;
                lo_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (lines[i] && !auto_ack[i] && auto_en[i]) begin
                    hi_cnt[i]++;
                    if (hi_cnt[i] == 3) begin
                        auto_ack[i] = 1'b1;
                        hi_cnt[i]   = 0;
                    end
                end else if (!lines[i] && auto_ack[i]) begin
                    lo_cnt[i]++;
                    if (lo_cnt[i] == 3) begin
                        auto_ack[i] = 1'b0;
                        lo_cnt[i]   = 0;
                    end
                end else begin
                    hi_cnt[i] = 0;
                    lo_cnt[i] = 0;
                end
            end
        end
    end

    // Monitor: every line rise and every done pulse is matched against the queue
    always @(negedge clk) begin
        if (rst) begin
            prev = '0;
        end else begin
            rise = lines & ~prev;
            if (rise != '0) begin
                check_eq("onehot", 32'($countones(lines) <= 1), 32'd1);
                if (exp_q.size() == 0) check_eq("rise_unexpected", {27'd0, rise}, 32'd0);
                else                   check_eq("sym_order", {27'd0, rise}, {26'd0, exp_q.pop_front()});
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) check_eq("done_unexpected", {26'd0, done, 5'd0}, 32'd0);
                else                   check_eq("done_order", {26'd0, done, 5'd0}, {26'd0, exp_q.pop_front()});
            end
            if (err) err_cnt++;
            prev = lines;
        end
    end

    task automatic push_frame(input logic ch, input logic up);
        exp_q.push_back({1'b0, LINE_FS});
        exp_q.push_back({1'b0, ch ? LINE_ONE : LINE_ZERO});
        exp_q.push_back({1'b0, LINE_X0});
        exp_q.push_back({1'b0, up ? LINE_ONE : LINE_ZERO});
        exp_q.push_back({1'b0, LINE_FE});
        exp_q.push_back(TOK_DONE);
    endtask

    task automatic send(input logic ch, input logic up);
        int n;
        n = 0;
        push_frame(ch, up);
        @(negedge clk);
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_before_send", {31'd0, cmd_ready}, 32'd1);
        cmd_valid   = 1'b1;
        cmd_channel = ch;
        cmd_up      = up;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("accept_latency", {31'd0, fs}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_wait", {31'd0, done}, 32'd1);
        check_eq("ready_with_done", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic wait_line(input logic [4:0] code);
        int n;
        n = 0;
        while ((lines & code) == '0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("line_wait", {27'd0, lines}, {27'd0, code});
    endtask

    initial begin
        int n;
        int d0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_channel = 1'b0;
        cmd_up      = 1'b0;
        force_ack   = '0;
        auto_en     = 5'b11111;
        repeat (3) @(negedge clk);
        check_eq("rst_lines", {27'd0, lines}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Channel 1 / up
        d0 = done_cnt;
        send(1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        check_eq("done_once_a", 32'(done_cnt - d0), 32'd1);
        check_eq("queue_empty_a", 32'(exp_q.size()), 32'd0);

        // Channel 2 / down
        send(1'b1, 1'b0);
        wait_done();
        @(negedge clk);
        check_eq("queue_empty_b", 32'(exp_q.size()), 32'd0);

        // Wrong ack while waiting on fs
        auto_en = 5'b11110;
        send(1'b0, 1'b0);
        @(negedge clk);
        force_ack = LINE_ONE;
        repeat (4) @(negedge clk);
        force_ack = '0;
        repeat (6) @(negedge clk);
        check_eq("wrong_ack_hold", {27'd0, lines}, {27'd0, LINE_FS});
        auto_en = 5'b11111;
        wait_done();
        @(negedge clk);
        check_eq("queue_empty_c", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame
        d0 = done_cnt;
        send(1'b1, 1'b1);
        wait_line(LINE_X0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_lines", {27'd0, lines}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        send(1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        check_eq("queue_empty_d", 32'(exp_q.size()), 32'd0);

        // Back-to-back with cmd_valid held; inputs after accept must not matter
        push_frame(1'b0, 1'b0);
        push_frame(1'b1, 1'b1);
        cmd_valid   = 1'b1;
        cmd_channel = 1'b0;
        cmd_up      = 1'b0;
        @(negedge clk);
        check_eq("b2b_first_fs", {31'd0, fs}, 32'd1);
        cmd_channel = 1'b1;
        cmd_up      = 1'b1;
        wait_done();
        @(negedge clk);
        check_eq("b2b_gap", {31'd0, fs}, 32'd1);
        cmd_valid = 1'b0;
        wait_done();
        @(negedge clk);
        check_eq("queue_empty_e", 32'(exp_q.size()), 32'd0);

`ifdef FRAME_TIMEOUT_EN
        // x0 never acknowledged
        d0 = done_cnt;
        auto_en = 5'b11101;
        send(1'b0, 1'b1);
        wait_line(LINE_X0);
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("to_cycles", 32'(n), 32'(TO_CYC + 1));
        check_eq("to_lines", {27'd0, lines}, 32'd0);
        check_eq("to_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check_eq("to_err_pulse", {31'd0, err}, 32'd0);
        exp_q.delete();
        auto_en = 5'b11111;
        repeat (10) @(negedge clk);
        check_eq("to_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("to_err_once", 32'(err_cnt), 32'd1);
`else
        n = 0;
        check_eq("err_never", 32'(err_cnt + n), 32'd0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
